// File: rtl/lockstep_pkg.sv
`default_nettype none
// lockstep_pkg: shared signature type, pair FSM states and the request-signature match rule
// used by every lockstep master/checker pair.
package lockstep_pkg;

  localparam int LS_MAX_DELAY = 7;

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } lockstep_sig_t;

  localparam int LS_SIG_W = $bits(lockstep_sig_t);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    ERROR = 2'd3
  } pair_state_e;

  // Idle cycles never mismatch; write payload only matters when wen is low.
  function automatic logic sig_match(input lockstep_sig_t a, input lockstep_sig_t b);
    logic m;
    if (a.req != b.req) begin
      m = 1'b0;
    end else if (!a.req) begin
      m = 1'b1;
    end else if ((a.add != b.add) || (a.wen != b.wen)) begin
      m = 1'b0;
    end else if (!a.wen) begin
      m = (a.wdata == b.wdata) && (a.be == b.be);
    end else begin
      m = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lockstep_pair_checker.sv
`default_nettype none
// lockstep_pair_checker: one master/checker pair -- master delay line, resync FSM,
// sticky error state and saturating mismatch counter.
module lockstep_pair_checker
  import lockstep_pkg::*;
#(
  parameter int DELAY = 2,
  parameter int CNT_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lockstep_mode_i,
  input  logic                sync_i,
  input  logic                clr_i,
  input  logic [LS_SIG_W-1:0] master_i,
  input  logic [LS_SIG_W-1:0] checker_i,
  output logic                checking_o,
  output logic                pair_err_o,
  output logic [CNT_W-1:0]    mismatch_cnt_o
);

  lockstep_sig_t dly_q [DELAY];
  pair_state_e   state_q, state_d;
  logic [2:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic          mismatch;
  logic          count_en;

  // The delay line shifts unconditionally so it is already primed when a resync arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= lockstep_sig_t'(master_i);
      for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign mismatch = !sig_match(dly_q[DELAY-1], lockstep_sig_t'(checker_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    count_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (lockstep_mode_i && sync_i) begin
          // With DELAY=1 the very next cycle is already the first compared one.
          if (DELAY == 1) begin
            state_d = CHECK;
          end else begin
            state_d = FILL;
            fill_d  = 3'(DELAY - 1);
          end
        end
      end
      FILL: begin
        if (!lockstep_mode_i) begin
          state_d = IDLE;
        end else begin
          fill_d = fill_q - 3'd1;
          if (fill_q <= 3'd1) state_d = CHECK;
        end
      end
      CHECK: begin
        if (!lockstep_mode_i) begin
          state_d = IDLE;
        end else if (!clr_i && mismatch) begin
          state_d  = ERROR;
          count_en = 1'b1;
        end
      end
      ERROR: begin
        count_en = mismatch;
        if (clr_i) state_d = lockstep_mode_i ? CHECK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign checking_o     = (state_q == CHECK);
  assign pair_err_o     = (state_q == ERROR);
  assign mismatch_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/lockstep_pair_checker_array.sv
`default_nettype none
// lockstep_pair_checker_array: groups cores into master/checker pairs (2p, 2p+1), checks each
// pair independently and raises one aggregate error interrupt.
module lockstep_pair_checker_array
  import lockstep_pkg::*;
#(
  parameter int NB_CORES = 8,
  parameter int DELAY    = 2,
  parameter int CNT_W    = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          lockstep_mode_i,
  input  logic [NB_CORES/2-1:0]         sync_i,
  input  logic [NB_CORES/2-1:0]         clr_i,
  input  logic [NB_CORES-1:0]           core_req_i,
  input  logic [NB_CORES*32-1:0]        core_add_i,
  input  logic [NB_CORES-1:0]           core_wen_i,
  input  logic [NB_CORES*32-1:0]        core_wdata_i,
  input  logic [NB_CORES*4-1:0]         core_be_i,
  output logic [NB_CORES/2-1:0]         checking_o,
  output logic [NB_CORES/2-1:0]         pair_err_o,
  output logic [NB_CORES/2*CNT_W-1:0]   mismatch_cnt_o,
  output logic                          err_irq_o
);

  localparam int NB_PAIRS = NB_CORES / 2;

  for (genvar p = 0; p < NB_PAIRS; p++) begin : g_pair
    logic [LS_SIG_W-1:0] master_sig;
    logic [LS_SIG_W-1:0] checker_sig;

    assign master_sig  = {core_req_i[2*p],   core_add_i[64*p +: 32],      core_wen_i[2*p],
                          core_wdata_i[64*p +: 32],      core_be_i[8*p +: 4]};
    assign checker_sig = {core_req_i[2*p+1], core_add_i[64*p+32 +: 32],   core_wen_i[2*p+1],
                          core_wdata_i[64*p+32 +: 32],   core_be_i[8*p+4 +: 4]};

    lockstep_pair_checker #(
      .DELAY (DELAY),
      .CNT_W (CNT_W)
    ) u_pair (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .lockstep_mode_i (lockstep_mode_i),
      .sync_i          (sync_i[p]),
      .clr_i           (clr_i[p]),
      .master_i        (master_sig),
      .checker_i       (checker_sig),
      .checking_o      (checking_o[p]),
      .pair_err_o      (pair_err_o[p]),
      .mismatch_cnt_o  (mismatch_cnt_o[p*CNT_W +: CNT_W])
    );
  end

  assign err_irq_o = |pair_err_o;

endmodule
`default_nettype wire

// File: tb/tb_lockstep_pair_checker_array.sv
`default_nettype none
// tb_lockstep_pair_checker_array: randomized traffic against a cycle-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_lockstep_pair_checker_array;

  localparam int NC    = 8;
  localparam int NP    = NC / 2;
  localparam int DELAY = 2;
  localparam int CW    = 8;
  localparam int SATV  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic [NP-1:0] sync = '0;
  logic [NP-1:0] clr = '0;
  logic [NC-1:0] req = '0;
  logic [NC*32-1:0] add = '0;
  logic [NC-1:0] wen = '0;
  logic [NC*32-1:0] wdata = '0;
  logic [NC*4-1:0] be = '0;
  logic [NP-1:0] checking;
  logic [NP-1:0] perr;
  logic [NP*CW-1:0] cnt;
  logic irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lockstep_pair_checker_array #(.NB_CORES(NC), .DELAY(DELAY), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .lockstep_mode_i(mode), .sync_i(sync), .clr_i(clr),
    .core_req_i(req), .core_add_i(add), .core_wen_i(wen), .core_wdata_i(wdata), .core_be_i(be),
    .checking_o(checking), .pair_err_o(perr), .mismatch_cnt_o(cnt), .err_irq_o(irq)
  );

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for the first compared cycle, 2 checking, 3 error
  int ph [NP];
  int start_c [NP];
  int mcnt [NP];
  int cyc;
  logic [69:0] hist [NP][$];

  function automatic logic [69:0] port_sig(input int k);
    return {req[k], add[32*k +: 32], wen[k], wdata[32*k +: 32], be[4*k +: 4]};
  endfunction

  function automatic bit ref_match(input logic [69:0] a, input logic [69:0] b);
    if (a[69] !== b[69]) return 1'b0;
    if (a[69] == 1'b0) return 1'b1;
    if (a[68:36] != b[68:36]) return 1'b0;
    if (a[36] == 1'b1) return 1'b1;
    return a[35:0] == b[35:0];
  endfunction

  function automatic void model_reset();
    cyc = 0;
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0; start_c[p] = 0; mcnt[p] = 0;
      hist[p].delete();
      for (int i = 0; i < DELAY; i++) hist[p].push_back('0);
    end
  endfunction

  function automatic void model_step();
    for (int p = 0; p < NP; p++) begin
      bit ok;
      bit counting;
      ok = ref_match(hist[p][0], port_sig(2*p+1));
      counting = !ok && ((ph[p] == 2 && mode) || ph[p] == 3);
      if (clr[p]) mcnt[p] = 0;
      else if (counting && mcnt[p] < SATV) mcnt[p] = mcnt[p] + 1;
      case (ph[p])
        0: if (mode && sync[p]) begin
             start_c[p] = cyc + DELAY;
             ph[p] = (cyc + 1 >= start_c[p]) ? 2 : 1;
           end
        1: if (!mode) ph[p] = 0;
           else if (cyc + 1 >= start_c[p]) ph[p] = 2;
        2: if (!mode) ph[p] = 0;
           else if (!clr[p] && !ok) ph[p] = 3;
        default: if (clr[p]) ph[p] = mode ? 2 : 0;
      endcase
      hist[p].push_back(port_sig(2*p));
      void'(hist[p].pop_front());
    end
    cyc++;
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    logic [NP-1:0] e_chk, e_err;
    logic [NP*CW-1:0] e_cnt;
    if (rst_n) model_step();
    #1;
    for (int p = 0; p < NP; p++) begin
      e_chk[p] = (ph[p] == 2);
      e_err[p] = (ph[p] == 3);
      e_cnt[p*CW +: CW] = CW'(mcnt[p]);
    end
    checks += 4;
    if (checking !== e_chk) begin errors++; $display("FAIL model_checking actual=%b expected=%b t=%0t", checking, e_chk, $time); end
    if (perr !== e_err) begin errors++; $display("FAIL model_pair_err actual=%b expected=%b t=%0t", perr, e_err, $time); end
    if (cnt !== e_cnt) begin errors++; $display("FAIL model_cnt actual=%h expected=%h t=%0t", cnt, e_cnt, $time); end
    if (irq !== (|e_err)) begin errors++; $display("FAIL model_irq actual=%b expected=%b t=%0t", irq, |e_err, $time); end
  end

  // ---------------- stimulus ----------------
  // ck_mode: 0 independent random, 1 exact copy 2 cycles late, 2 forced mismatch, 3 benign differences
  int ck_mode [NP];
  logic [69:0] past1 [NP];
  logic [69:0] past2 [NP];
  logic ov_m_en = 1'b0;
  logic [69:0] ov_m = '0;
  logic corrupt0 = 1'b0;

  function automatic logic [69:0] rand_sig();
    logic r;
    r = ($urandom_range(0, 3) != 0);
    return {r, 32'($urandom), 1'($urandom_range(0, 1)), 32'($urandom), 4'($urandom_range(0, 15))};
  endfunction

  task automatic drive_cycle();
    for (int p = 0; p < NP; p++) begin
      logic [69:0] m, c;
      m = rand_sig();
      if (p == 0 && ov_m_en) m = ov_m;
      case (ck_mode[p])
        1: c = past2[p];
        2: begin
             c = past2[p];
             if (!c[69]) c[69] = 1'b1;
             else c[68:37] = c[68:37] ^ 32'h1;
           end
        3: begin
             c = past2[p];
             if (!c[69]) c[68:37] = ~c[68:37];
             else if (c[36]) begin c[35:4] = ~c[35:4]; c[3:0] = ~c[3:0]; end
           end
        default: c = rand_sig();
      endcase
      if (p == 0 && corrupt0) c[35:4] = 32'hDEADBEEF;
      past2[p] = past1[p];
      past1[p] = m;
      req[2*p] = m[69]; add[64*p +: 32] = m[68:37]; wen[2*p] = m[36];
      wdata[64*p +: 32] = m[35:4]; be[8*p +: 4] = m[3:0];
      req[2*p+1] = c[69]; add[64*p+32 +: 32] = c[68:37]; wen[2*p+1] = c[36];
      wdata[64*p+32 +: 32] = c[35:4]; be[8*p+4 +: 4] = c[3:0];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drive_cycle();
  endtask

  initial begin
    model_reset();
    for (int p = 0; p < NP; p++) begin ck_mode[p] = 0; past1[p] = '0; past2[p] = '0; end

    // reset state
    tick(); tick();
    pin("reset_checking", 32'(checking), 0);
    pin("reset_pair_err", 32'(perr), 0);
    pin("reset_cnt", 32'(cnt), 0);
    pin("reset_irq", 32'(irq), 0);
    rst_n = 1'b1;

    // mode off: random traffic and a stray sync keep everything idle
    for (int i = 0; i < 100; i++) begin
      sync = (i == 50) ? 4'hF : 4'h0;
      tick();
    end
    sync = '0;
    tick();
    pin("mode0_checking", 32'(checking), 0);
    pin("mode0_cnt", 32'(cnt), 0);

    // resync with exact 2-cycle-late reproduction
    for (int p = 0; p < NP; p++) ck_mode[p] = 1;
    mode = 1'b1;
    tick(); tick(); tick();
    sync = 4'hF;
    tick();
    sync = '0;
    pin("fill_not_checking", 32'(checking[0]), 0);
    tick();
    pin("checking_at_T2", 32'(checking), 32'hF);
    repeat (1000) tick();
    pin("clean_stream_err", 32'(perr), 0);

    // single write-data mismatch on pair 0
    ov_m = {1'b1, 32'h1000_0040, 1'b0, 32'hDEADBEEE, 4'hF};
    ov_m_en = 1'b1;
    tick();
    ov_m_en = 1'b0;
    tick();
    corrupt0 = 1'b1;
    tick();
    corrupt0 = 1'b0;
    tick();
    pin("wdata_err0", 32'(perr[0]), 1);
    pin("wdata_irq", 32'(irq), 1);
    pin("wdata_cnt0", 32'(cnt[0 +: CW]), 1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    pin("clr_back_to_check", 32'(checking[0]), 1);
    pin("clr_cnt0", 32'(cnt[0 +: CW]), 0);

    // differences that must not count
    ck_mode[0] = 3;
    repeat (200) tick();
    pin("benign_cnt0", 32'(cnt[0 +: CW]), 0);
    pin("benign_err0", 32'(perr[0]), 0);

    // saturation then clear coincident with a mismatch
    ck_mode[0] = 2;
    repeat (300) tick();
    pin("sat_cnt0", 32'(cnt[0 +: CW]), SATV);
    pin("sat_err0", 32'(perr[0]), 1);
    clr[0] = 1'b1;
    ck_mode[0] = 1;
    tick();
    clr[0] = 1'b0;
    pin("clr_wins_cnt0", 32'(cnt[0 +: CW]), 0);
    pin("clr_wins_check0", 32'(checking[0]), 1);

    // sticky error across a mode drop
    ck_mode[1] = 2;
    tick();
    ck_mode[1] = 1;
    tick();
    pin("pair1_err", 32'(perr[1]), 1);
    mode = 1'b0;
    tick();
    pin("drop_pair1_sticky", 32'(perr[1]), 1);
    pin("drop_pair0_idle", 32'(checking[0]), 0);
    pin("drop_irq", 32'(irq), 1);
    clr = 4'b0010;
    tick();
    clr = '0;
    pin("clr1_err", 32'(perr[1]), 0);
    pin("clr1_idle", 32'(checking[1]), 0);

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      for (int p = 0; p < NP; p++) begin
        sync[p] = ($urandom_range(0, 15) == 0);
        clr[p]  = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 49) == 0) ck_mode[p] = int'($urandom_range(0, 5)) % 4;
      end
      tick();
    end
    sync = '0; clr = '0;

    // async reset in the middle of a fill
    mode = 1'b0; clr = 4'hF;
    tick();
    clr = '0; mode = 1'b1;
    for (int p = 0; p < NP; p++) ck_mode[p] = 1;
    tick(); tick();
    sync = 4'b1110;
    tick();
    sync = '0;
    tick();
    ck_mode[2] = 2;
    repeat (5) tick();
    ck_mode[2] = 1;
    sync = 4'b0001;
    tick();
    sync = '0;
    pin("pre_reset_err2", 32'(perr[2]), 1);
    pin("pre_reset_fill0", 32'(checking[0]), 0);
    rst_n = 1'b0;
    #1;
    pin("async_checking", 32'(checking), 0);
    pin("async_err", 32'(perr), 0);
    pin("async_cnt", 32'(cnt), 0);
    pin("async_irq", 32'(irq), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
